// File: rtl/miriscv_pkg.sv
// miriscv shared constants: load/store size codes and the LSU state encoding.
package miriscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE
    } lsu_state_e;

endpackage

// File: rtl/miriscv_lsu_if.sv
// miriscv data memory port: request/grant/response bus between LSU and memory.
interface miriscv_lsu_if;

    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_we, data_be,
        output data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata
    );

    modport slave (
        input  data_req, data_we, data_be,
        input  data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata
    );

endinterface

// File: rtl/miriscv_lsu_align.sv
// miriscv LSU datapath: legality check, byte enables, store replication,
// and load extract with sign/zero extension.
module miriscv_lsu_align
    import miriscv_pkg::*;
(
    input  logic [2:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic        legal,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic        is_b;
    logic        is_h;
    logic        is_w;
    logic [31:0] sh;

    assign is_b = (st_size == LDST_B) || (st_size == LDST_BU);
    assign is_h = (st_size == LDST_H) || (st_size == LDST_HU);
    assign is_w = (st_size == LDST_W);

    always_comb begin
        legal = 1'b0;
        be    = 4'b0000;
        wdata = st_data;
        unique case (1'b1)
            is_b: begin
                legal = 1'b1;
                be    = 4'b0001 << st_off;
                wdata = {4{st_data[7:0]}};
            end
            is_h: begin
                legal = ~st_off[0];
                be    = 4'b0011 << st_off;
                wdata = {2{st_data[15:0]}};
            end
            is_w: begin
                legal = (st_off == 2'b00);
                be    = 4'b1111;
            end
            default: ;
        endcase
    end

    // The addressed lane is moved down to bit 0 before extension.
    assign sh = rdata >> {ld_off, 3'b000};

    always_comb begin
        ld_data = sh;
        case (ld_size)
            LDST_B:  ld_data = {{24{sh[7]}}, sh[7:0]};
            LDST_BU: ld_data = {24'h0, sh[7:0]};
            LDST_H:  ld_data = {{16{sh[15]}}, sh[15:0]};
            LDST_HU: ld_data = {16'h0, sh[15:0]};
            default: ld_data = sh;
        endcase
    end

endmodule

// File: rtl/miriscv_lsu.sv
// miriscv load-store unit: sequences one memory access at a time
// over the req/gnt/rvalid bus and stalls the core until it completes.
module miriscv_lsu
    import miriscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_fault_o,
    miriscv_lsu_if.master data_bus
);

    lsu_state_e  state_q;
    lsu_state_e  state_d;
    logic        start;
    logic        legal;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld_data;

    logic        req_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] data_q;

    miriscv_lsu_align u_align (
        .st_size (lsu_size_i),
        .st_off  (lsu_addr_i[1:0]),
        .st_data (lsu_data_i),
        .legal   (legal),
        .be      (be),
        .wdata   (wdata),
        .ld_size (size_q),
        .ld_off  (off_q),
        .rdata   (data_bus.data_rdata),
        .ld_data (ld_data)
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            LSU_IDLE: begin
                if (lsu_req_i && legal) begin
                    state_d = LSU_REQ;
                    start   = 1'b1;
                end
            end
            LSU_REQ: begin
                if (data_bus.data_gnt) state_d = LSU_WAIT;
            end
            LSU_WAIT: begin
                if (data_bus.data_rvalid) state_d = LSU_DONE;
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LSU_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= LDST_B;
            off_q   <= 2'b00;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            if (start) begin
                req_q   <= 1'b1;
                we_q    <= lsu_we_i;
                be_q    <= be;
                addr_q  <= {lsu_addr_i[31:2], 2'b00};
                wdata_q <= wdata;
                size_q  <= lsu_size_i;
                off_q   <= lsu_addr_i[1:0];
            end else if (state_q == LSU_REQ && data_bus.data_gnt) begin
                req_q <= 1'b0;
            end
            // Store acknowledges leave the last load result intact.
            if (state_q == LSU_WAIT && data_bus.data_rvalid && !we_q) begin
                data_q <= ld_data;
            end
        end
    end

    assign lsu_data_o      = data_q;
    assign lsu_fault_o     = (state_q == LSU_IDLE) & lsu_req_i & ~legal;
    assign lsu_stall_req_o = lsu_req_i & legal & (state_q != LSU_DONE);

    assign data_bus.data_req   = req_q;
    assign data_bus.data_we    = we_q;
    assign data_bus.data_be    = be_q;
    assign data_bus.data_addr  = addr_q;
    assign data_bus.data_wdata = wdata_q;

endmodule

// File: tb/tb_miriscv_lsu.sv
// miriscv_lsu bench: core-side stimulus plus a memory responder,
// with expected bus/result values queued per access.
module tb_miriscv_lsu;
    import miriscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_req = 1'b0;
    logic        lsu_we = 1'b0;
    logic [2:0]  lsu_size = LDST_W;
    logic [31:0] lsu_addr = 32'h0;
    logic [31:0] lsu_wd = 32'h0;
    logic [31:0] lsu_rd;
    logic        stall;
    logic        fault;

    miriscv_lsu_if bus ();

    miriscv_lsu dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .lsu_req_i       (lsu_req),
        .lsu_we_i        (lsu_we),
        .lsu_size_i      (lsu_size),
        .lsu_addr_i      (lsu_addr),
        .lsu_data_i      (lsu_wd),
        .lsu_data_o      (lsu_rd),
        .lsu_stall_req_o (stall),
        .lsu_fault_o     (fault),
        .data_bus        (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic [3:0]  be;
        logic        we;
        int          stall;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at #1 after a rising edge with the LSU in IDLE.
    // Stall length is 3 + grant-wait cycles + rvalid-wait cycles.
    task automatic do_access(input logic we, input logic [2:0] sz,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int gd,
                             input int rvd, input logic [3:0] ebe,
                             input logic [31:0] ewd, input logic [31:0] eld);
        exp_t e;
        int   reqc;
        int   waitc;
        int   stc;
        bit   granted;
        bit   done;
        e.addr  = {addr[31:2], 2'b00};
        e.wdata = ewd;
        e.ld    = eld;
        e.be    = ebe;
        e.we    = we;
        e.stall = 3 + gd + rvd;
        sb.push_back(e);
        lsu_req  = 1'b1;
        lsu_we   = we;
        lsu_size = sz;
        lsu_addr = addr;
        lsu_wd   = wd;
        reqc = 0;
        waitc = -1;
        stc = 0;
        granted = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (stall) stc++;
            bus.data_gnt    = 1'b0;
            bus.data_rvalid = 1'b0;
            bus.data_rdata  = 32'h5A5A5A5A;
            if (granted) begin
                waitc++;
                if (waitc == rvd) begin
                    bus.data_rvalid = 1'b1;
                    bus.data_rdata  = rd;
                end
            end else if (bus.data_req) begin
                chk("bus_addr", bus.data_addr, sb[0].addr);
                chk("bus_be", {28'h0, bus.data_be}, {28'h0, sb[0].be});
                chk("bus_we", {31'h0, bus.data_we}, {31'h0, sb[0].we});
                chk("bus_wdata", bus.data_wdata, sb[0].wdata);
                if (reqc == gd) bus.data_gnt = 1'b1;
                reqc++;
            end
            @(posedge clk);
            #1;
            if (bus.data_gnt) granted = 1'b1;
            if (bus.data_rvalid) done = 1'b1;
            bus.data_gnt    = 1'b0;
            bus.data_rvalid = 1'b0;
        end
        e = sb.pop_front();
        if (!done) begin
            chk("timeout", 32'h0, 32'h1);
        end else begin
            @(negedge clk);
            chk("stall_done", {31'h0, stall}, 32'h0);
            chk("stall_len", stc, e.stall);
            chk("ld_data", lsu_rd, e.ld);
            @(posedge clk);
            #1;
        end
        lsu_req = 1'b0;
    endtask

    task automatic do_fault(input logic [2:0] sz, input logic [31:0] addr);
        lsu_req  = 1'b1;
        lsu_we   = 1'b0;
        lsu_size = sz;
        lsu_addr = addr;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("fault", {31'h0, fault}, 32'h1);
            chk("fault_stall", {31'h0, stall}, 32'h0);
            chk("fault_req", {31'h0, bus.data_req}, 32'h0);
        end
        @(posedge clk);
        #1;
        lsu_req = 1'b0;
    endtask

    initial begin
        bus.data_gnt    = 1'b0;
        bus.data_rvalid = 1'b0;
        bus.data_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", {31'h0, bus.data_req}, 32'h0);
        chk("rst_we", {31'h0, bus.data_we}, 32'h0);
        chk("rst_be", {28'h0, bus.data_be}, 32'h0);
        chk("rst_addr", bus.data_addr, 32'h0);
        chk("rst_wdata", bus.data_wdata, 32'h0);
        chk("rst_ld", lsu_rd, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1;

        do_access(0, LDST_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0,
                  4'b1111, 32'h0, 32'hDEADBEEF);
        do_access(0, LDST_B, 32'h103, 32'h0, 32'h80123456, 0, 0,
                  4'b1000, 32'h0, 32'hFFFFFF80);
        do_access(0, LDST_BU, 32'h103, 32'h0, 32'h80123456, 0, 0,
                  4'b1000, 32'h0, 32'h00000080);
        do_access(1, LDST_H, 32'h102, 32'h0000ABCD, 32'hFFFFFFFF, 0, 0,
                  4'b1100, 32'hABCDABCD, 32'h00000080);
        do_access(0, LDST_H, 32'h102, 32'h0, 32'h80011234, 0, 0,
                  4'b1100, 32'h0, 32'hFFFF8001);
        do_access(0, LDST_HU, 32'h102, 32'h0, 32'h80011234, 1, 0,
                  4'b1100, 32'h0, 32'h00008001);
        do_access(1, LDST_B, 32'h101, 32'h000000A5, 32'h0, 0, 2,
                  4'b0010, 32'hA5A5A5A5, 32'h00008001);
        do_access(1, LDST_W, 32'h104, 32'h12345678, 32'h0, 1, 1,
                  4'b1111, 32'h12345678, 32'h00008001);
        // Grant low for the issue cycle plus two REQ cycles, rvalid two
        // cycles after grant: six stall cycles.
        do_access(0, LDST_W, 32'h108, 32'h0, 32'hCAFEF00D, 2, 1,
                  4'b1111, 32'h0, 32'hCAFEF00D);

        do_fault(LDST_W, 32'h101);
        do_fault(LDST_H, 32'h103);
        do_fault(3'd3, 32'h100);
        do_fault(3'd7, 32'h100);

        // Abandon a load in WAIT with reset; its late rvalid is ignored.
        lsu_req  = 1'b1;
        lsu_we   = 1'b0;
        lsu_size = LDST_W;
        lsu_addr = 32'h200;
        @(posedge clk);
        #1;
        bus.data_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus.data_gnt = 1'b0;
        lsu_req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("wrst_req", {31'h0, bus.data_req}, 32'h0);
        chk("wrst_be", {28'h0, bus.data_be}, 32'h0);
        chk("wrst_addr", bus.data_addr, 32'h0);
        chk("wrst_ld", lsu_rd, 32'h0);
        bus.data_rvalid = 1'b1;
        bus.data_rdata  = 32'h87654321;
        @(posedge clk);
        #1;
        bus.data_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rv_ld", lsu_rd, 32'h0);
        chk("late_rv_req", {31'h0, bus.data_req}, 32'h0);
        chk("late_rv_stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1;

        do_access(0, LDST_B, 32'h201, 32'h0, 32'h0000_7F00, 0, 0,
                  4'b0010, 32'h0, 32'h0000007F);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
